// File: rtl/uart_sink.sv
// rtl/uart_sink.sv - receive-side byte sink: edge-detected capture into a FWFT FIFO with checksum, line count and sticky overflow
//
// Ports:
//   clock            in   global clock, all state updates on the rising edge
//   tick_reset       in   asynchronous active-high reset
//   tick_valid       in   byte-valid level/pulse from uart_rx; its rising edge requests a push
//   tick_data        in   byte from uart_rx, sampled on the tick_valid rising edge
//   tick_pop         in   reader consumes the head byte this cycle
//   get_data_ret     out  head-of-FIFO byte, 8'h00 when empty
//   get_empty_ret    out  FIFO holds no bytes
//   get_full_ret     out  FIFO holds depth bytes
//   get_count_ret    out  current occupancy
//   get_lines_ret    out  number of accepted line_char bytes (mod 2^16)
//   get_overflow_ret out  sticky, a byte was dropped because the FIFO was full
//   get_checksum_ret out  sum of all accepted bytes (mod 2^32)

module uart_sink #(
    parameter int         depth     = 16,
    parameter logic [7:0] line_char = 8'h0A
) (
    input  logic                       clock,
    input  logic                       tick_reset,
    input  logic                       tick_valid,
    input  logic [7:0]                 tick_data,
    input  logic                       tick_pop,
    output logic [7:0]                 get_data_ret,
    output logic                       get_empty_ret,
    output logic                       get_full_ret,
    output logic [$clog2(depth+1)-1:0] get_count_ret,
    output logic [15:0]                get_lines_ret,
    output logic                       get_overflow_ret,
    output logic [31:0]                get_checksum_ret
);

    localparam int addr_w  = $clog2(depth);
    localparam int ptr_w   = addr_w + 1;
    localparam int count_w = $clog2(depth + 1);

    logic [7:0]        mem [depth];
    logic [ptr_w-1:0]  wr_ptr;
    logic [ptr_w-1:0]  rd_ptr;
    logic [ptr_w-1:0]  fill;
    logic              prev_valid;
    logic [15:0]       lines;
    logic [31:0]       checksum;
    logic              overflow;

    logic              fifo_empty;
    logic              fifo_full;
    logic              push_req;
    logic              pop_ok;
    logic              push_ok;
    logic              drop;

    // A held-high valid level produces exactly one push: only its rising edge counts.
    assign push_req = tick_valid && !prev_valid;

    // The extra pointer MSB separates full (MSBs differ) from empty (identical pointers).
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[addr_w-1:0] == rd_ptr[addr_w-1:0]) &&
                        (wr_ptr[addr_w] != rd_ptr[addr_w]);

    // All decisions use pre-edge state. A push into a full FIFO is still
    // accepted when a pop frees the head slot in the same cycle.
    assign pop_ok  = tick_pop && !fifo_empty;
    assign push_ok = push_req && (!fifo_full || pop_ok);
    assign drop    = push_req && fifo_full && !pop_ok;

    assign fill = wr_ptr - rd_ptr;

    always_ff @(posedge clock or posedge tick_reset) begin
        if (tick_reset) begin
            prev_valid <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lines      <= 16'd0;
            checksum   <= 32'd0;
            overflow   <= 1'b0;
        end else begin
            prev_valid <= tick_valid;
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr   <= wr_ptr + 1'b1;
                checksum <= checksum + {24'b0, tick_data};
                if (tick_data == line_char) begin
                    lines <= lines + 16'd1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[addr_w-1:0]] <= tick_data;
        end
    end

    // First-word-fall-through: the head is read straight from registered state.
    assign get_data_ret     = fifo_empty ? 8'h00 : mem[rd_ptr[addr_w-1:0]];
    assign get_empty_ret    = fifo_empty;
    assign get_full_ret     = fifo_full;
    assign get_count_ret    = count_w'(fill);
    assign get_lines_ret    = lines;
    assign get_overflow_ret = overflow;
    assign get_checksum_ret = checksum;

endmodule

// File: tb/tb_uart_sink.sv
// tb/tb_uart_sink.sv - self-checking bench for uart_sink: vector table, scoreboard queue and corner-case sequences

module tb_uart_sink;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          tick_reset = 1'b0;
    logic          tick_valid = 1'b0;
    logic [7:0]    tick_data = 8'h00;
    logic          tick_pop = 1'b0;
    logic [7:0]    get_data_ret;
    logic          get_empty_ret;
    logic          get_full_ret;
    logic [CW-1:0] get_count_ret;
    logic [15:0]   get_lines_ret;
    logic          get_overflow_ret;
    logic [31:0]   get_checksum_ret;

    uart_sink #(.depth(DEPTH), .line_char(8'h0A)) dut (
        .clock            (clock),
        .tick_reset       (tick_reset),
        .tick_valid       (tick_valid),
        .tick_data        (tick_data),
        .tick_pop         (tick_pop),
        .get_data_ret     (get_data_ret),
        .get_empty_ret    (get_empty_ret),
        .get_full_ret     (get_full_ret),
        .get_count_ret    (get_count_ret),
        .get_lines_ret    (get_lines_ret),
        .get_overflow_ret (get_overflow_ret),
        .get_checksum_ret (get_checksum_ret)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: expected FIFO contents plus statistics.
    logic [7:0]  sb[$];
    logic [31:0] m_chk;
    logic [15:0] m_lines;
    logic        m_ovf;

    typedef struct {
        logic        push;
        logic        pop;
        logic [7:0]  data;
        int          exp_count;
        logic [7:0]  exp_data;
        logic        exp_ovf;
        logic [31:0] exp_chk;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_chk   = 32'd0;
        m_lines = 16'd0;
        m_ovf   = 1'b0;
    endtask

    // Applies one clock edge to the model, using pre-edge model state.
    task automatic model_edge(input logic push_edge, input logic [7:0] d, input logic p);
        logic pop_ok;
        logic push_ok;
        pop_ok  = p && (sb.size() > 0);
        push_ok = push_edge && ((sb.size() < DEPTH) || pop_ok);
        if (pop_ok) void'(sb.pop_front());
        if (push_ok) begin
            sb.push_back(d);
            m_chk = m_chk + {24'b0, d};
            if (d == 8'h0A) m_lines = m_lines + 16'd1;
        end else if (push_edge) begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic compare_model(input string tag);
        logic [7:0] head;
        head = (sb.size() > 0) ? sb[0] : 8'h00;
        check({tag, ".count"},    32'(get_count_ret),    32'(sb.size()));
        check({tag, ".empty"},    32'(get_empty_ret),    32'(sb.size() == 0));
        check({tag, ".full"},     32'(get_full_ret),     32'(sb.size() == DEPTH));
        check({tag, ".data"},     32'(get_data_ret),     32'(head));
        check({tag, ".checksum"}, get_checksum_ret,      m_chk);
        check({tag, ".lines"},    32'(get_lines_ret),    32'(m_lines));
        check({tag, ".overflow"}, 32'(get_overflow_ret), 32'(m_ovf));
    endtask

    // One-cycle valid pulse and/or pop, then an idle cycle so the next pulse is a fresh edge.
    task automatic step(input logic v, input logic [7:0] d, input logic p, input string tag);
        @(negedge clock);
        if (p && sb.size() > 0) check({tag, ".pop_head"}, 32'(get_data_ret), 32'(sb[0]));
        tick_valid = v;
        tick_data  = d;
        tick_pop   = p;
        @(posedge clock);
        model_edge(v, d, p);
        @(negedge clock);
        tick_valid = 1'b0;
        tick_pop   = 1'b0;
        compare_model(tag);
    endtask

    task automatic push_held(input logic [7:0] d, input int n);
        @(negedge clock);
        tick_valid = 1'b1;
        tick_data  = d;
        tick_pop   = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_edge(i == 0, d, 1'b0);
            @(negedge clock);
        end
        tick_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        compare_model("held");
    endtask

    // Reset asserted between edges; outputs must settle before the next edge.
    task automatic do_reset(input string tag);
        @(posedge clock);
        #2;
        tick_reset = 1'b1;
        #1;
        check({tag, ".rst_empty"},    32'(get_empty_ret),    32'd1);
        check({tag, ".rst_full"},     32'(get_full_ret),     32'd0);
        check({tag, ".rst_count"},    32'(get_count_ret),    32'd0);
        check({tag, ".rst_data"},     32'(get_data_ret),     32'd0);
        check({tag, ".rst_lines"},    32'(get_lines_ret),    32'd0);
        check({tag, ".rst_overflow"}, 32'(get_overflow_ret), 32'd0);
        check({tag, ".rst_checksum"}, get_checksum_ret,      32'd0);
        model_clear();
        @(negedge clock);
        tick_reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h41, 1, 8'h41, 1'b0, 32'h41};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 32'h41};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 32'h41};
        tbl[3] = '{1'b1, 1'b0, 8'h0A, 1, 8'h0A, 1'b0, 32'h4B};
        tbl[4] = '{1'b1, 1'b1, 8'h10, 1, 8'h10, 1'b0, 32'h5B};

        model_clear();
        do_reset("init");

        // Table: single byte, pop to empty, pop while empty, line byte, push+pop.
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].push, tbl[i].data, tbl[i].pop, $sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl_count", i), 32'(get_count_ret), 32'(tbl[i].exp_count));
            check($sformatf("vec%0d.tbl_data", i), 32'(get_data_ret), 32'(tbl[i].exp_data));
            check($sformatf("vec%0d.tbl_ovf", i), 32'(get_overflow_ret), 32'(tbl[i].exp_ovf));
            check($sformatf("vec%0d.tbl_chk", i), get_checksum_ret, tbl[i].exp_chk);
        end

        // "hi\n" with valid held 3 cycles per byte.
        do_reset("hi");
        push_held(8'h68, 3);
        push_held(8'h69, 3);
        push_held(8'h0A, 3);
        check("hi.count", 32'(get_count_ret), 32'd3);
        check("hi.lines", 32'(get_lines_ret), 32'd1);
        check("hi.checksum", get_checksum_ret, 32'hDB);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, "hi_pop");
        check("hi.drained", 32'(get_empty_ret), 32'd1);

        // Overflow: 17 bytes into 16 entries.
        do_reset("ovf");
        for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0, "ovf_push");
        check("ovf.full", 32'(get_full_ret), 32'd1);
        check("ovf.count", 32'(get_count_ret), 32'd16);
        check("ovf.flag", 32'(get_overflow_ret), 32'd1);
        check("ovf.checksum", get_checksum_ret, 32'd120);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("ovf.order%0d", i), 32'(get_data_ret), 32'(i));
            step(1'b0, 8'h00, 1'b1, "ovf_pop");
        end
        check("ovf.sticky", 32'(get_overflow_ret), 32'd1);

        // Full plus simultaneous push/pop.
        do_reset("fullpp");
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, "fullpp_push");
        step(1'b1, 8'hAA, 1'b1, "fullpp_both");
        check("fullpp.count", 32'(get_count_ret), 32'd16);
        check("fullpp.ovf", 32'(get_overflow_ret), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fullpp.order%0d", i), 32'(get_data_ret), (i == 15) ? 32'hAA : 32'(i + 1));
            step(1'b0, 8'h00, 1'b1, "fullpp_pop");
        end

        // Reset mid-operation.
        do_reset("mid");
        step(1'b1, 8'h0A, 1'b0, "mid_push");
        step(1'b1, 8'h0A, 1'b0, "mid_push");
        step(1'b1, 8'h01, 1'b0, "mid_push");
        step(1'b1, 8'h02, 1'b0, "mid_push");
        step(1'b1, 8'h03, 1'b0, "mid_push");
        check("mid.count", 32'(get_count_ret), 32'd5);
        check("mid.lines", 32'(get_lines_ret), 32'd2);
        do_reset("mid");
        step(1'b1, 8'h55, 1'b0, "mid_after");
        check("mid.readback", 32'(get_data_ret), 32'h55);
        check("mid.after_count", 32'(get_count_ret), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
